// File: rtl/lc330_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lc330_mc_ctrl_if
// Purpose  : Control/status bundle between the LC330 multi-cycle controller
//            and its datapath. The master side is the controller; the slave
//            side is the datapath (IR decode, ALU flag, memory handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface lc330_mc_ctrl_if;
    logic [2:0]  opcode;
    logic        eq;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        mdr_we;
    logic        ab_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_op;
    logic        alu_b_sel;
    logic        aluout_we;
    logic        rf_we;
    logic        rf_dst_sel;
    logic [1:0]  rf_data_sel;
    logic        halted;
    logic [3:0]  state;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    modport master (
        input  opcode, eq, mem_ack,
        output mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, ab_we, pc_we,
               pc_src, alu_op, alu_b_sel, aluout_we, rf_we, rf_dst_sel,
               rf_data_sel, halted, state, cyc_cnt, ret_cnt
    );

    modport slave (
        output opcode, eq, mem_ack,
        input  mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, ab_we, pc_we,
               pc_src, alu_op, alu_b_sel, aluout_we, rf_we, rf_dst_sel,
               rf_data_sel, halted, state, cyc_cnt, ret_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lc330_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc330_mc_ctrl
// Purpose  : Multi-cycle control unit for the LC330 core. Walks each
//            instruction through FETCH/DECODE/EXEC/MEM/WB and decodes every
//            datapath enable and mux select from the current state.
// Options  : LC330_PERF_CNT_EN - adds cycle and retired-instruction counters;
//            when undefined the counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module lc330_mc_ctrl (
    input  wire              clk,
    input  wire              rst,
    lc330_mc_ctrl_if.master  bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_MEM    = 4'd3;
    localparam logic [3:0] S_WB     = 4'd4;
    localparam logic [3:0] S_HALTED = 4'd5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    logic [3:0] state_q, state_d;

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state: memory states wait for ack, EXEC branches on opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (bus.opcode)
                    OP_ADD, OP_NAND: state_d = S_WB;
                    OP_LW, OP_SW:    state_d = S_MEM;
                    OP_HALT:         state_d = S_HALTED;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (bus.mem_ack) state_d = (bus.opcode == OP_SW) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; everything is held at zero while rst is asserted
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.mdr_we       = 1'b0;
        bus.ab_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = 2'd0;
        bus.alu_op       = 2'd0;
        bus.alu_b_sel    = 1'b0;
        bus.aluout_we    = 1'b0;
        bus.rf_we        = 1'b0;
        bus.rf_dst_sel   = 1'b0;
        bus.rf_data_sel  = 2'd0;
        bus.halted       = 1'b0;
        bus.state        = rst ? 4'd0 : state_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                    end
                end
                S_DECODE: bus.ab_we = 1'b1;
                S_EXEC: begin
                    case (bus.opcode)
                        OP_ADD, OP_NAND: begin
                            bus.alu_op    = (bus.opcode == OP_NAND) ? 2'd1 : 2'd0;
                            bus.aluout_we = 1'b1;
                        end
                        OP_LW, OP_SW: begin
                            bus.alu_b_sel = 1'b1;
                            bus.aluout_we = 1'b1;
                        end
                        OP_BEQ: begin
                            bus.alu_op = 2'd2;
                            if (bus.eq) begin
                                bus.pc_we  = 1'b1;
                                bus.pc_src = 2'd1;
                            end
                        end
                        OP_JALR: begin
                            // Link uses the already-incremented PC; target is A from DECODE
                            bus.rf_we       = 1'b1;
                            bus.rf_data_sel = 2'd2;
                            bus.pc_we       = 1'b1;
                            bus.pc_src      = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = (bus.opcode == OP_SW);
                    bus.mdr_we       = bus.mem_ack && (bus.opcode == OP_LW);
                end
                S_WB: begin
                    bus.rf_we = 1'b1;
                    if (bus.opcode == OP_LW) begin
                        bus.rf_data_sel = 2'd1;
                    end else begin
                        bus.rf_dst_sel = 1'b1;
                    end
                end
                S_HALTED: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LC330_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    // Counter next values: retire on return to FETCH from the tail states or on halting
    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ret_cnt_d = ret_cnt_q;
        if (((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
            ((state_d == S_FETCH) || (state_d == S_HALTED))) begin
            ret_cnt_d = ret_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= 32'd0;
            ret_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign bus.cyc_cnt = rst ? 32'd0 : cyc_cnt_q;
    assign bus.ret_cnt = rst ? 32'd0 : ret_cnt_q;
`else
    assign bus.cyc_cnt = 32'd0;
    assign bus.ret_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc330_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc330_mc_ctrl
// Purpose  : Directed self-checking bench for lc330_mc_ctrl. An instruction-
//            level model emits the expected control word for every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc330_mc_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       ab_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_b_sel;
        logic       aluout_we;
        logic       rf_we;
        logic       rf_dst_sel;
        logic [1:0] rf_data_sel;
        logic       halted;
    } cw_t;

    typedef struct {
        cw_t         w;
        logic [31:0] cyc;
        logic [31:0] ret;
        bit          in_rst;
        int          phase;
    } exp_t;

    localparam logic [2:0] ADD = 3'b000, NAND = 3'b001, LW = 3'b010, SW = 3'b011;
    localparam logic [2:0] BEQ = 3'b100, JALR = 3'b101, HALT = 3'b110, NOOP = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc330_mc_ctrl_if bus_if ();
    lc330_mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if.master));

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ret = 0;
    logic [3:0]  phase_state [0:5];
    bit          phase_seen  [0:5];

    initial for (int i = 0; i < 6; i++) phase_seen[i] = 1'b0;

    function automatic cw_t dut_word();
        cw_t a;
        a.mem_req = bus_if.mem_req;       a.mem_we = bus_if.mem_we;
        a.mem_addr_sel = bus_if.mem_addr_sel; a.ir_we = bus_if.ir_we;
        a.mdr_we = bus_if.mdr_we;         a.ab_we = bus_if.ab_we;
        a.pc_we = bus_if.pc_we;           a.pc_src = bus_if.pc_src;
        a.alu_op = bus_if.alu_op;         a.alu_b_sel = bus_if.alu_b_sel;
        a.aluout_we = bus_if.aluout_we;   a.rf_we = bus_if.rf_we;
        a.rf_dst_sel = bus_if.rf_dst_sel; a.rf_data_sel = bus_if.rf_data_sel;
        a.halted = bus_if.halted;
        return a;
    endfunction

    // Compare process: checks the DUT outputs of each cycle against the model
    always @(negedge clk) begin
        exp_t e;
        cw_t  a;
        logic [31:0] ec, er;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_word();
            checks++;
            if (a !== e.w) begin
                failures++;
                $display("FAIL ctrl_word t=%0t phase=%0d actual=%b required=%b", $time, e.phase, a, e.w);
            end
`ifdef LC330_PERF_CNT_EN
            ec = e.in_rst ? 32'd0 : e.cyc;
            er = e.in_rst ? 32'd0 : e.ret;
`else
            ec = 32'd0;
            er = 32'd0;
`endif
            checks++;
            if (bus_if.cyc_cnt !== ec || bus_if.ret_cnt !== er) begin
                failures++;
                $display("FAIL counters t=%0t actual cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                         $time, bus_if.cyc_cnt, bus_if.ret_cnt, ec, er);
            end
            if (e.in_rst) begin
                checks++;
                if (bus_if.state !== 4'd0) begin
                    failures++;
                    $display("FAIL state_in_rst actual=%0d required=0", bus_if.state);
                end
            end else if (e.phase >= 0) begin
                if (phase_seen[e.phase]) begin
                    checks++;
                    if (bus_if.state !== phase_state[e.phase]) begin
                        failures++;
                        $display("FAIL state_stable phase=%0d actual=%0d required=%0d",
                                 e.phase, bus_if.state, phase_state[e.phase]);
                    end
                end else begin
                    phase_seen[e.phase]  = 1'b1;
                    phase_state[e.phase] = bus_if.state;
                end
            end
        end
    end

    // One bench cycle: drive inputs, queue the expected outputs, advance the model clock
    task automatic step(input bit r, input logic [2:0] op, input bit e, input bit a,
                        input cw_t w, input int ph);
        exp_t x;
        @(negedge clk);
        rst = r;
        bus_if.opcode  = op;
        bus_if.eq      = e;
        bus_if.mem_ack = a;
        x.w = w; x.cyc = m_cyc; x.ret = m_ret; x.in_rst = r; x.phase = ph;
        exp_q.push_back(x);
        @(posedge clk);
        if (r) begin
            m_cyc = 0;
            m_ret = 0;
        end else begin
            m_cyc = m_cyc + 1;
        end
    endtask

    task automatic do_reset(input int n, input logic [2:0] op);
        for (int i = 0; i < n; i++) step(1'b1, op, 1'b0, 1'b0, '0, -1);
    endtask

    function automatic logic [2:0] rnd_op();
        return 3'($urandom_range(0, 7));
    endfunction

    // Instruction-level model: emits each cycle's expected control word.
    // abort_mw >= 0 stops after that many MEM wait cycles (instruction abandoned).
    task automatic run_instr(input logic [2:0] op, input bit eqv, input int fw,
                             input int mw, input int abort_mw, output int n);
        cw_t w;
        bit  e;
        n = 0;
        e = (op == BEQ) ? eqv : 1'($urandom_range(0, 1));
        // fetch: request held through waits, IR and PC+1 loaded on ack
        for (int i = 0; i < fw; i++) begin
            w = '0; w.mem_req = 1;
            step(0, rnd_op(), e, 0, w, 0); n++;
        end
        w = '0; w.mem_req = 1; w.ir_we = 1; w.pc_we = 1; w.pc_src = 0;
        step(0, rnd_op(), e, 1, w, 0); n++;
        // decode (a stray ack must be ignored)
        w = '0; w.ab_we = 1;
        step(0, op, e, 1, w, 1); n++;
        // execute
        w = '0;
        case (op)
            ADD:     begin w.alu_op = 0; w.aluout_we = 1; end
            NAND:    begin w.alu_op = 1; w.aluout_we = 1; end
            LW, SW:  begin w.alu_op = 0; w.alu_b_sel = 1; w.aluout_we = 1; end
            BEQ:     begin w.alu_op = 2; if (eqv) begin w.pc_we = 1; w.pc_src = 1; end end
            JALR:    begin w.rf_we = 1; w.rf_dst_sel = 0; w.rf_data_sel = 2; w.pc_we = 1; w.pc_src = 2; end
            default: ;
        endcase
        step(0, op, e, 1, w, 2); n++;
        if (op == LW || op == SW) begin
            for (int i = 0; i < mw; i++) begin
                if (abort_mw >= 0 && i == abort_mw) return;
                w = '0; w.mem_req = 1; w.mem_addr_sel = 1; w.mem_we = (op == SW);
                step(0, op, e, 0, w, 3); n++;
            end
            if (abort_mw >= 0) return;
            w = '0; w.mem_req = 1; w.mem_addr_sel = 1; w.mem_we = (op == SW); w.mdr_we = (op == LW);
            step(0, op, e, 1, w, 3); n++;
        end
        if (op == ADD || op == NAND || op == LW) begin
            w = '0; w.rf_we = 1;
            if (op == LW) begin w.rf_dst_sel = 0; w.rf_data_sel = 1; end
            else          begin w.rf_dst_sel = 1; w.rf_data_sel = 0; end
            step(0, op, e, 1, w, 4); n++;
        end
        m_ret = m_ret + 1;
    endtask

    task automatic halted_cycles(input int k);
        cw_t w;
        for (int i = 0; i < k; i++) begin
            w = '0; w.halted = 1;
            step(0, rnd_op(), 1'($urandom_range(0, 1)), 1, w, 5);
        end
    endtask

    task automatic chk_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        int n;
        bus_if.opcode = 0; bus_if.eq = 0; bus_if.mem_ack = 0;
        do_reset(2, NOOP);

        run_instr(ADD,  0, 0, 0, -1, n); chk_lit("add_cycles", n, 4);
        run_instr(NAND, 0, 2, 0, -1, n); chk_lit("nand_fetch_wait2_cycles", n, 6);
        run_instr(LW,   0, 0, 2, -1, n); chk_lit("lw_mem_wait2_cycles", n, 7);
        run_instr(LW,   0, 0, 0, -1, n); chk_lit("lw_cycles", n, 5);
        run_instr(SW,   0, 0, 0, -1, n); chk_lit("sw_cycles", n, 4);
        run_instr(SW,   0, 1, 1, -1, n); chk_lit("sw_waits_cycles", n, 6);
        run_instr(BEQ,  1, 0, 0, -1, n); chk_lit("beq_taken_cycles", n, 3);
        run_instr(BEQ,  0, 0, 0, -1, n); chk_lit("beq_not_taken_cycles", n, 3);
        run_instr(JALR, 0, 0, 0, -1, n); chk_lit("jalr_cycles", n, 3);
        run_instr(NOOP, 0, 0, 0, -1, n); chk_lit("noop_cycles", n, 3);
        run_instr(ADD,  0, 1, 0, -1, n); chk_lit("add_fetch_wait_cycles", n, 5);

        // reset during the second MEM wait cycle of a lw
        run_instr(LW, 0, 0, 5, 1, n);
        do_reset(1, LW);
        run_instr(ADD, 0, 0, 0, -1, n); chk_lit("add_after_reset_cycles", n, 4);
        run_instr(BEQ, 1, 2, 0, -1, n);

        run_instr(HALT, 0, 0, 0, -1, n); chk_lit("halt_cycles", n, 3);
        halted_cycles(10);

        do_reset(1, HALT);
        run_instr(NOOP, 0, 0, 0, -1, n);
        run_instr(JALR, 0, 1, 0, -1, n);

        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
